// File: rtl/inputbuf_pkg.sv
// Shared defaults and helpers for the input-buffer modulo counter chain.
package inputbuf_pkg;

    localparam int unsigned NDIG_DEF = 2;
    localparam int unsigned W_DEF    = 3;
    localparam int unsigned MOD0_DEF = 4;

    // Bit offset of digit idx inside a packed NDIG*W vector.
    function automatic int unsigned dig_lsb(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/counter_mod_digit.sv
// One modulo-m counter digit; m==0 encodes 2^W, m==1 holds 0 and is always terminal.
module counter_mod_digit
    import inputbuf_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         step_i,
    input  logic         up_i,
    input  logic [W-1:0] din_i,
    input  logic [W-1:0] m_i,
    input  logic [W-1:0] m_next_i,
    output logic [W-1:0] q_o,
    output logic         term_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] q_q, q_d;
    logic [W-1:0] last_cur;
    logic [W-1:0] last_next;

    // Terminal is judged against the modulus in force this cycle; reload values use the
    // modulus that will be in force after the edge, so a wrap into new moduli stays in range.
    assign last_cur  = m_i - ONE;
    assign last_next = m_next_i - ONE;
    assign term_o    = up_i ? (q_q == last_cur) : (q_q == '0);
    assign q_o       = q_q;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (load_i) begin
            q_d = ((m_next_i != '0) && (din_i >= m_next_i)) ? last_next : din_i;
        end else if (step_i) begin
            if (up_i) begin
                q_d = term_o ? '0 : q_q + ONE;
            end else begin
                q_d = term_o ? last_next : q_q - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/counter_mod_chain.sv
// Cascaded chain of NDIG runtime-modulus digits with shadowed modulus update and wrap pulse.
module counter_mod_chain
    import inputbuf_pkg::*;
#(
    parameter int unsigned NDIG = NDIG_DEF,
    parameter int unsigned W    = W_DEF,
    parameter int unsigned MOD0 = MOD0_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              up_i,
    input  logic              load_i,
    input  logic [NDIG*W-1:0] din_i,
    input  logic [NDIG*W-1:0] mod_in_i,
    input  logic              mod_wr_i,
    output logic [NDIG*W-1:0] q_o,
    output logic              co_o,
    output logic              wrap_o,
    output logic              mod_pend_o
);

    localparam logic [W-1:0]      MOD0_ENC = W'(MOD0);
    localparam logic [NDIG*W-1:0] RST_MODS = {NDIG{MOD0_ENC}};

    logic [NDIG*W-1:0] act_q, act_d;
    logic [NDIG*W-1:0] shadow_q, shadow_d;
    logic              pend_q, pend_d;
    logic              wrap_q, wrap_d;
    logic [NDIG:0]     carry;
    logic [NDIG-1:0]   term;
    logic              apply;

    assign carry[0] = en_i;
    assign co_o     = carry[NDIG];

    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        localparam int unsigned LSB = dig_lsb(i, W);

        assign carry[i+1] = carry[i] & term[i];

        counter_mod_digit #(
            .W (W)
        ) u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr_i    (clr_i),
            .load_i   (load_i),
            .step_i   (carry[i]),
            .up_i     (up_i),
            .din_i    (din_i[LSB +: W]),
            .m_i      (act_q[LSB +: W]),
            .m_next_i (act_d[LSB +: W]),
            .q_o      (q_o[LSB +: W]),
            .term_o   (term[i])
        );
    end

    // Moduli only switch at sequence boundaries: full wrap, clear or load.
    assign apply = co_o | clr_i | load_i;

    always_comb begin
        act_d    = act_q;
        shadow_d = mod_wr_i ? mod_in_i : shadow_q;
        pend_d   = pend_q | mod_wr_i;
        wrap_d   = co_o & ~clr_i & ~load_i;
        if (apply) begin
            pend_d = 1'b0;
            if (mod_wr_i) begin
                act_d = mod_in_i;
            end else if (pend_q) begin
                act_d = shadow_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q    <= RST_MODS;
            shadow_q <= RST_MODS;
            pend_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            act_q    <= act_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            wrap_q   <= wrap_d;
        end
    end

    assign wrap_o     = wrap_q;
    assign mod_pend_o = pend_q;

endmodule
